// File: rtl/lsu_mem_if.sv
// Request/response and memory-port bundle for the load/store initiator.
// master = the initiator block; slave = the pipeline plus memory side.
interface lsu_mem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    modport master (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_a, mem_wd
    );

    modport slave (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_a, mem_wd
    );
endinterface

// File: rtl/lsu_mem_master.sv
// Load/store initiator: one byte-addressed request at a time, lane select and
// extend on loads, read-modify-write on sub-word stores, one response per request.
//
// state | meaning
// IDLE  | ready; accept request, check funct3/alignment/range
// LOAD  | read word, lane-select and extend into rdata_q
// MERGE | read word, splice store byte/halfword into merge_q
// WRITE | one-cycle memory write of merge_q
// RESP  | one-cycle response pulse
module lsu_mem_master #(
    parameter int MEM_WORDS = 1024
) (
    input  logic      clk,
    input  logic      rst,
    lsu_mem_if.master bus
);
    typedef enum logic [2:0] {IDLE, LOAD, MERGE, WRITE, RESP} state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] merge_q, merge_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        bad_funct3, misaligned, out_of_range, acc_err;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_ext, merged;

    always_comb begin
        if (bus.req_we) begin
            bad_funct3 = !(bus.req_funct3 inside {3'b000, 3'b001, 3'b010});
        end else begin
            bad_funct3 = !(bus.req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        end
        misaligned   = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                       ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
        out_of_range = ({2'b00, bus.req_addr[31:2]} >= 32'(MEM_WORDS));
        acc_err      = bad_funct3 || misaligned || out_of_range;
    end

    always_comb begin
        case (addr_q[1:0])
            2'd0:    rd_byte = bus.mem_rd[7:0];
            2'd1:    rd_byte = bus.mem_rd[15:8];
            2'd2:    rd_byte = bus.mem_rd[23:16];
            default: rd_byte = bus.mem_rd[31:24];
        endcase
        rd_half = addr_q[1] ? bus.mem_rd[31:16] : bus.mem_rd[15:0];

        case (funct3_q)
            3'b000:  load_ext = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  load_ext = {{16{rd_half[15]}}, rd_half};
            3'b010:  load_ext = bus.mem_rd;
            3'b100:  load_ext = {24'd0, rd_byte};
            3'b101:  load_ext = {16'd0, rd_half};
            default: load_ext = 32'd0;
        endcase

        merged = bus.mem_rd;
        case (funct3_q[1:0])
            2'b00: begin
                case (addr_q[1:0])
                    2'd0:    merged[7:0]   = wdata_q[7:0];
                    2'd1:    merged[15:8]  = wdata_q[7:0];
                    2'd2:    merged[23:16] = wdata_q[7:0];
                    default: merged[31:24] = wdata_q[7:0];
                endcase
            end
            2'b01: begin
                if (addr_q[1]) merged[31:16] = wdata_q[15:0];
                else           merged[15:0]  = wdata_q[15:0];
            end
            default: merged = wdata_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        merge_d  = merge_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    we_d     = bus.req_we;
                    funct3_d = bus.req_funct3;
                    addr_d   = bus.req_addr;
                    wdata_d  = bus.req_wdata;
                    rdata_d  = 32'd0;
                    err_d    = 1'b0;
                    if (acc_err) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else if (!bus.req_we) begin
                        state_d = LOAD;
                    end else if (bus.req_funct3[1:0] == 2'b10) begin
                        merge_d = bus.req_wdata;
                        state_d = WRITE;
                    end else begin
                        state_d = MERGE;
                    end
                end
            end
            LOAD: begin
                rdata_d = load_ext;
                state_d = RESP;
            end
            MERGE: begin
                merge_d = merged;
                state_d = WRITE;
            end
            WRITE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            merge_q  <= 32'd0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            merge_q  <= merge_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Memory outputs decode straight from state so reset kills mem_we at once.
    logic mem_active;
    assign mem_active     = (state_q == LOAD) || (state_q == MERGE) || (state_q == WRITE);
    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
    assign bus.mem_we     = (state_q == WRITE);
    assign bus.mem_a      = mem_active ? {2'b00, addr_q[31:2]} : 32'd0;
    assign bus.mem_wd     = (state_q == WRITE) ? merge_q : 32'd0;

    logic unused_we;
    assign unused_we = we_q;
endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master with a 1024-word behavioural memory.
module tb_lsu_mem_master;
    logic clk = 1'b0;
    logic rst = 1'b1;
    lsu_mem_if bus();

    lsu_mem_master #(.MEM_WORDS(1024)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    logic [31:0] mem [1024];
    assign bus.mem_rd = (bus.mem_a < 32'd1024) ? mem[bus.mem_a[9:0]] : 32'd0;
    always @(posedge clk) if (bus.mem_we && (bus.mem_a < 32'd1024)) mem[bus.mem_a[9:0]] <= bus.mem_wd;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic        err;
        logic [31:0] rdata;
        logic        wr;
        int          wcyc;
        logic [31:0] wa;
        logic [31:0] wd;
    } vec_t;

    function automatic vec_t mkv(logic we, logic [2:0] f3, logic [31:0] addr, logic [31:0] wdata,
                                 int lat, logic err, logic [31:0] rdata,
                                 logic wr, int wcyc, logic [31:0] wa, logic [31:0] wd);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.lat = lat; v.err = err;
        v.rdata = rdata; v.wr = wr; v.wcyc = wcyc; v.wa = wa; v.wd = wd;
        return v;
    endfunction

    vec_t vecs[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
    endtask

    initial begin
        vec_t v;
        int resp_cyc, resp_cnt, wr_cnt, wr_cyc, ready_bad, rv_cnt;
        logic got_err;
        logic [31:0] got_rd, wa, wd;
        logic [31:0] t6_addr [3];
        logic [2:0]  t6_f3 [3];
        logic [31:0] t6_exp [3];
        int acc_cyc [3];
        int acc_n, resp_n, last_acc, cyc;

        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        mem[8] = 32'h11223344;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'd0;
        bus.req_addr = 32'd0; bus.req_wdata = 32'd0;

        //          we    f3      addr        wdata         lat err rdata        wr  wc  wa         wd
        vecs.push_back(mkv(1'b1, 3'b010, 32'h10,   32'hDEADBEEF, 2, 0, 32'h0,        1, 1, 32'd4,   32'hDEADBEEF));
        vecs.push_back(mkv(1'b0, 3'b010, 32'h10,   32'h0,        2, 0, 32'hDEADBEEF, 0, 0, 32'd0,   32'h0));
        vecs.push_back(mkv(1'b1, 3'b000, 32'h11,   32'hFFFFFF55, 3, 0, 32'h0,        1, 2, 32'd4,   32'hDEAD55EF));
        vecs.push_back(mkv(1'b0, 3'b000, 32'h11,   32'h0,        2, 0, 32'h00000055, 0, 0, 32'd0,   32'h0));
        vecs.push_back(mkv(1'b0, 3'b000, 32'h13,   32'h0,        2, 0, 32'hFFFFFFDE, 0, 0, 32'd0,   32'h0));
        vecs.push_back(mkv(1'b0, 3'b100, 32'h13,   32'h0,        2, 0, 32'h000000DE, 0, 0, 32'd0,   32'h0));
        vecs.push_back(mkv(1'b1, 3'b001, 32'h12,   32'hABCD8001, 3, 0, 32'h0,        1, 2, 32'd4,   32'h800155EF));
        vecs.push_back(mkv(1'b0, 3'b001, 32'h12,   32'h0,        2, 0, 32'hFFFF8001, 0, 0, 32'd0,   32'h0));
        vecs.push_back(mkv(1'b0, 3'b101, 32'h12,   32'h0,        2, 0, 32'h00008001, 0, 0, 32'd0,   32'h0));
        vecs.push_back(mkv(1'b0, 3'b001, 32'h10,   32'h0,        2, 0, 32'h000055EF, 0, 0, 32'd0,   32'h0));
        vecs.push_back(mkv(1'b0, 3'b000, 32'h10,   32'h0,        2, 0, 32'hFFFFFFEF, 0, 0, 32'd0,   32'h0));
        vecs.push_back(mkv(1'b0, 3'b010, 32'h13,   32'h0,        1, 1, 32'h0,        0, 0, 32'd0,   32'h0));
        vecs.push_back(mkv(1'b1, 3'b001, 32'h01,   32'h1234,     1, 1, 32'h0,        0, 0, 32'd0,   32'h0));
        vecs.push_back(mkv(1'b1, 3'b010, 32'h1000, 32'h12345678, 1, 1, 32'h0,        0, 0, 32'd0,   32'h0));
        vecs.push_back(mkv(1'b1, 3'b100, 32'h10,   32'h12345678, 1, 1, 32'h0,        0, 0, 32'd0,   32'h0));
        vecs.push_back(mkv(1'b0, 3'b011, 32'h10,   32'h0,        1, 1, 32'h0,        0, 0, 32'd0,   32'h0));
        vecs.push_back(mkv(1'b1, 3'b010, 32'hFFC,  32'h0BADF00D, 2, 0, 32'h0,        1, 1, 32'h3FF, 32'h0BADF00D));
        vecs.push_back(mkv(1'b0, 3'b010, 32'hFFC,  32'h0,        2, 0, 32'h0BADF00D, 0, 0, 32'd0,   32'h0));
        vecs.push_back(mkv(1'b0, 3'b010, 32'h10,   32'h0,        2, 0, 32'h800155EF, 0, 0, 32'd0,   32'h0));
        vecs.push_back(mkv(1'b0, 3'b010, 32'h0,    32'h0,        2, 0, 32'h0,        0, 0, 32'd0,   32'h0));

        #12;
        chk("rst_req_ready",  32'(bus.req_ready),  32'd1);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_rdata", bus.resp_rdata,      32'd0);
        chk("rst_resp_err",   32'(bus.resp_err),   32'd0);
        chk("rst_mem_we",     32'(bus.mem_we),     32'd0);
        chk("rst_mem_a",      bus.mem_a,           32'd0);
        chk("rst_mem_wd",     bus.mem_wd,          32'd0);
        step();
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            chk($sformatf("v%0d_ready", i), 32'(bus.req_ready), 32'd1);
            drive(v.we, v.f3, v.addr, v.wdata);
            step();
            bus.req_valid = 1'b0;
            resp_cyc = 0; resp_cnt = 0; wr_cnt = 0; wr_cyc = 0; ready_bad = 0;
            got_err = 1'b0; got_rd = 32'd0; wa = 32'd0; wd = 32'd0;
            for (int k = 1; k <= 5; k++) begin
                if (bus.resp_valid) begin
                    resp_cnt++;
                    if (resp_cnt == 1) begin
                        resp_cyc = k; got_err = bus.resp_err; got_rd = bus.resp_rdata;
                    end
                end
                if (bus.mem_we) begin
                    wr_cnt++; wr_cyc = k; wa = bus.mem_a; wd = bus.mem_wd;
                end
                if (bus.req_ready && (k <= v.lat)) ready_bad++;
                if (k < 5) step();
            end
            chk($sformatf("v%0d_resp_cnt", i),  32'(resp_cnt),  32'd1);
            chk($sformatf("v%0d_latency", i),   32'(resp_cyc),  32'(v.lat));
            chk($sformatf("v%0d_err", i),       32'(got_err),   32'(v.err));
            chk($sformatf("v%0d_rdata", i),     got_rd,         v.rdata);
            chk($sformatf("v%0d_rdata_hold", i), bus.resp_rdata, v.rdata);
            chk($sformatf("v%0d_ready_busy", i), 32'(ready_bad), 32'd0);
            chk($sformatf("v%0d_wr_cnt", i),    32'(wr_cnt),    32'(v.wr));
            if (v.wr) begin
                chk($sformatf("v%0d_wr_cyc", i), 32'(wr_cyc), 32'(v.wcyc));
                chk($sformatf("v%0d_wr_a", i),   wa,          v.wa);
                chk($sformatf("v%0d_wr_d", i),   wd,          v.wd);
            end
        end

        // Reset during the WRITE cycle of an sb must abort with no write.
        drive(1'b1, 3'b000, 32'h20, 32'h00000077);
        step();
        bus.req_valid = 1'b0;
        chk("t5_merge_a", bus.mem_a, 32'd8);
        step();
        chk("t5_write_we", 32'(bus.mem_we), 32'd1);
        chk("t5_write_wd", bus.mem_wd, 32'h11223377);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_we",    32'(bus.mem_we),     32'd0);
        chk("t5_rst_ready", 32'(bus.req_ready),  32'd1);
        chk("t5_rst_a",     bus.mem_a,           32'd0);
        chk("t5_rst_resp",  32'(bus.resp_valid), 32'd0);
        step();
        rst = 1'b0;
        rv_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            if (bus.resp_valid) rv_cnt++;
            step();
        end
        chk("t5_no_resp",   32'(rv_cnt), 32'd0);
        chk("t5_mem_kept",  mem[8], 32'h11223344);
        chk("t5_ready_end", 32'(bus.req_ready), 32'd1);

        // Three loads with req_valid held high throughout.
        t6_addr[0] = 32'h10;  t6_f3[0] = 3'b010; t6_exp[0] = 32'h800155EF;
        t6_addr[1] = 32'hFFC; t6_f3[1] = 3'b010; t6_exp[1] = 32'h0BADF00D;
        t6_addr[2] = 32'h11;  t6_f3[2] = 3'b100; t6_exp[2] = 32'h00000055;
        acc_n = 0; resp_n = 0; last_acc = -100; cyc = 0;
        for (int i = 0; i < 3; i++) acc_cyc[i] = 0;
        while ((resp_n < 3) && (cyc < 60)) begin
            if (acc_n < 3) drive(1'b0, t6_f3[acc_n], t6_addr[acc_n], 32'd0);
            else bus.req_valid = 1'b0;
            #1;
            chk($sformatf("t6_ready_c%0d", cyc), 32'(bus.req_ready), 32'(cyc > last_acc + 2));
            if (bus.resp_valid) begin
                chk($sformatf("t6_rdata%0d", resp_n), bus.resp_rdata, t6_exp[resp_n]);
                chk($sformatf("t6_lat%0d", resp_n), 32'(cyc), 32'(acc_cyc[resp_n] + 2));
                resp_n++;
            end
            if (bus.req_ready && bus.req_valid) begin
                acc_cyc[acc_n] = cyc; last_acc = cyc; acc_n++;
            end
            step();
            cyc++;
        end
        bus.req_valid = 1'b0;
        chk("t6_resp_count", 32'(resp_n), 32'd3);
        rv_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            if (bus.resp_valid) rv_cnt++;
            step();
        end
        chk("t6_extra_resp", 32'(rv_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
